// File: rtl/mem_show_pkg.sv
// Shared types and helpers for the memory show sequencer.
package mem_show_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdReq,
    StRdWait,
    StShow
  } state_e;

  // Byte lanes per 32-bit word shown on the display.
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;

  // Fill pattern: word at addr holds seed + addr (wraps mod 2**32).
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/mem_show_if.sv
// RAM bus plus display drive bundled between the sequencer (master) and the
// RAM / LED display side (slave).
interface mem_show_if #(
  parameter int unsigned ADDR_W = 6
);

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [31:0]       mem_dout;
  logic [31:0]       r_data;
  logic [1:0]        select;
  logic              write_reg;

  modport master (
    output mem_addr,
    output mem_din,
    output mem_we,
    output r_data,
    output select,
    output write_reg,
    input  mem_dout
  );

  modport slave (
    input  mem_addr,
    input  mem_din,
    input  mem_we,
    input  r_data,
    input  select,
    input  write_reg,
    output mem_dout
  );

endinterface

// File: rtl/lane_dwell_timer.sv
// Dwell timer for auto mode: counts while run is high and pulses expire on the
// DWELL-th consecutive cycle. Dropping run, or an expiry, restarts the count,
// so every lane gets a full dwell from the cycle it is first shown.
module lane_dwell_timer #(
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q;

  // Expiry fires on the last count of the dwell window.
  always_comb begin
    expire = run && (cnt_q == LastCnt);
  end

  // Count up while running; restart on stop or expiry.
  always_ff @(posedge clk) begin
    if (rst || !run || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_show_ctrl.sv
// Memory show sequencer: fills a single-port RAM with pat(SEED, addr), then
// reads each word back and walks the display through its four byte lanes.
// Optional feature macro: MEM_SHOW_AUTO_EN. When defined, lanes advance on a
// DWELL-cycle timer and step is ignored; otherwise each step pulse advances.
module mem_show_ctrl
  import mem_show_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORDS  = 16,
  parameter logic [31:0] SEED   = 32'h1234_5600,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DWELL  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  mem_show_if.master bus,
  output logic       busy,
  output logic       done
);

  // Comparisons against the last index avoid forming WORDS itself, which does
  // not fit in ADDR_W bits when WORDS == 2**ADDR_W.
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORDS - 1);
  localparam int unsigned       LatW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LatW-1:0]   LastLat  = LatW'(RD_LAT - 1);
  localparam logic [LANE_W-1:0] LastLane = LANE_W'(LANES - 1);

  // An out-of-range build never leaves IDLE rather than misbehaving.
  localparam bit CfgOk = (WORDS >= 1) && (64'(WORDS) <= (64'd1 << ADDR_W)) &&
                         (RD_LAT >= 1) && (DWELL >= 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LatW-1:0]   lat_q;
  logic [31:0]       r_data_q;
  logic [LANE_W-1:0] select_q;
  logic              done_q;

  logic start_ok;
  logic advance;
  logic last_addr;
  logic last_lane;
  logic last_lat;

  assign start_ok  = start && CfgOk;
  assign last_addr = (addr_q == LastAddr);
  assign last_lane = (select_q == LastLane);
  assign last_lat  = (lat_q == LastLat);

`ifdef MEM_SHOW_AUTO_EN
  logic dwell_expire;
  logic unused_step;

  assign unused_step = step;

  lane_dwell_timer #(
    .DWELL (DWELL)
  ) u_lane_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state_q == StShow),
    .expire (dwell_expire)
  );

  assign advance = dwell_expire;
`else
  assign advance = step;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StWrite;
      end
      StWrite: begin
        if (last_addr) state_d = StRdReq;
      end
      StRdReq: begin
        state_d = StRdWait;
      end
      StRdWait: begin
        if (last_lat) state_d = StShow;
      end
      StShow: begin
        if (advance && last_lane) state_d = last_addr ? StIdle : StRdReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address, latency, capture and lane registers; done pulses on the final advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      lat_q    <= '0;
      r_data_q <= '0;
      select_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) addr_q <= '0;
        end
        StWrite: begin
          addr_q <= last_addr ? '0 : addr_q + 1'b1;
        end
        StRdReq: begin
          lat_q <= '0;
        end
        StRdWait: begin
          lat_q <= lat_q + 1'b1;
          if (last_lat) begin
            r_data_q <= bus.mem_dout;
            select_q <= '0;
          end
        end
        StShow: begin
          if (advance) begin
            if (!last_lane) begin
              select_q <= select_q + 1'b1;
            end else if (!last_addr) begin
              addr_q <= addr_q + 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state; display values come from registers.
  always_comb begin
    bus.mem_we    = (state_q == StWrite);
    bus.write_reg = (state_q == StWrite);
    bus.mem_addr  = (state_q == StIdle) ? '0 : addr_q;
    bus.mem_din   = (state_q == StWrite) ? pat(SEED, 32'(addr_q)) : '0;
    bus.r_data    = r_data_q;
    bus.select    = select_q;
    busy          = (state_q != StIdle);
    done          = done_q;
  end

endmodule

// File: tb/tb_mem_show_ctrl.sv
// Scoreboard bench for mem_show_ctrl: accepted starts push the expected write
// beats, display (word, lane) sequence and end-of-run record; monitors pop and
// compare whenever the DUT writes, changes the display or pulses done.
module tb_mem_show_ctrl;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned WORDS  = 8;
  localparam logic [31:0] SEED   = 32'h1234_5600;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DWELL  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic step;
  logic busy;
  logic done;

  mem_show_if #(.ADDR_W(ADDR_W)) bus ();

  mem_show_ctrl #(
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS),
    .SEED   (SEED),
    .RD_LAT (RD_LAT),
    .DWELL  (DWELL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .step  (step),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on the edge, read data appears RD_LAT edges later.
  logic [31:0] ram [2**ADDR_W];
  logic [31:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    rd_pipe[0] <= ram[bus.mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_dout = rd_pipe[RD_LAT-1];

  // Scoreboard state.
  wr_t         wr_q[$];
  logic [33:0] disp_q[$];
  logic [31:0] end_q[$];
  int unsigned start_cyc_q[$];

  int          checks = 0;
  int          errors = 0;
  int          runs_done = 0;
  int unsigned cyc = 0;
  logic        rst_last = 1'b1;
  logic [33:0] disp_prev = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_last <= rst;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of one run: every word written in address order, then each
  // word shown on lanes 0..3, ending with the last word held on lane 3.
  task automatic push_run();
    for (int a = 0; a < int'(WORDS); a++) begin
      wr_q.push_back('{addr: ADDR_W'(a), data: SEED + 32'(a)});
      for (int l = 0; l < 4; l++) disp_q.push_back({SEED + 32'(a), 2'(l)});
    end
    end_q.push_back(SEED + 32'(WORDS - 1));
    start_cyc_q.push_back(cyc);
  endtask

  // Monitor: compares outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    wr_t         ew;
    logic [33:0] ed;
    logic [31:0] ee;
    int unsigned sc;
    logic [33:0] cur;

    check("write_reg_vs_we", bus.write_reg, bus.mem_we);

    if (bus.mem_we) begin
      check("write_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        ew = wr_q.pop_front();
        check("write_addr", bus.mem_addr, ew.addr);
        check("write_data", bus.mem_din, ew.data);
      end
    end

    cur = {bus.r_data, bus.select};
    if (!rst && !rst_last && cur != disp_prev) begin
      check("display_expected", disp_q.size() != 0, 1);
      if (disp_q.size() != 0) begin
        ed = disp_q.pop_front();
        check("display_word", bus.r_data, ed[33:2]);
        check("display_lane", bus.select, ed[1:0]);
      end
    end
    disp_prev = cur;

    if (done) begin
      check("done_expected", end_q.size() != 0, 1);
      if (end_q.size() != 0) begin
        ee = end_q.pop_front();
        sc = start_cyc_q.pop_front();
        check("done_busy", busy, 0);
        check("done_r_data_held", bus.r_data, ee);
        check("done_select_held", bus.select, 3);
        check("done_display_drained", disp_q.size(), 0);
`ifdef MEM_SHOW_AUTO_EN
        check("auto_run_cycles", cyc - sc, 1 + WORDS * (2 + RD_LAT + 4 * DWELL));
`endif
      end
      runs_done++;
    end
  end

  // One stimulus cycle, entered and left at posedge+1.
  task automatic tick(input bit allow_start);
    start = allow_start && ($urandom_range(7) == 0);
    step  = ($urandom_range(2) == 0);
    if (start && !busy && !rst) push_run();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      tick(0);
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    int  n;
    int  runs_before;
    bit  hit;

    rst   = 1'b1;
    start = 1'b0;
    step  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_we", bus.mem_we, 0);
    check("reset_mem_addr", bus.mem_addr, 0);
    check("reset_mem_din", bus.mem_din, 0);
    check("reset_write_reg", bus.write_reg, 0);
    check("reset_r_data", bus.r_data, 0);
    check("reset_select", bus.select, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random runs with start/step noise in every state.
    n = 0;
    while (runs_done < 4 && n < 20000) begin
      tick(1);
      n++;
    end
    check("random_runs_completed", runs_done >= 4, 1);
    wait_idle("idle_after_random");

    // Reset in the middle of a write burst.
    start = 1'b1;
    push_run();
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_we && bus.mem_addr == ADDR_W'(5)) begin
        hit = 1'b1;
        break;
      end
      step = ($urandom_range(1) == 0);
      @(posedge clk);
      #1;
    end
    check("reached_addr5", hit, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_q.delete();
    disp_q.delete();
    end_q.delete();
    start_cyc_q.delete();
    @(negedge clk);
    check("midreset_mem_we", bus.mem_we, 0);
    check("midreset_busy", busy, 0);
    check("midreset_select", bus.select, 0);
    check("midreset_r_data", bus.r_data, 0);
    @(posedge clk);
    #1;

    // Restart after reset must begin again at address 0 and complete.
    start = 1'b1;
    push_run();
    runs_before = runs_done;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (runs_done == runs_before && n < 5000) begin
      tick(0);
      n++;
    end
    check("restart_run_completed", runs_done, runs_before + 1);
    repeat (3) tick(0);

    check("write_queue_empty", wr_q.size(), 0);
    check("display_queue_empty", disp_q.size(), 0);
    check("done_queue_empty", end_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
